// File: rtl/mcu_global_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mcu_global_sequencer_pkg
// Purpose : Global FSM encodings broadcast to the local AXI-Lite fetch FSMs,
//           plus the error codes reported by the global sequencer.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mcu_global_sequencer_pkg;

  localparam int GLO_FSM_WIDTH = 3;

  // Encodings are shared with the local fetch FSMs; do not renumber.
  typedef enum logic [GLO_FSM_WIDTH-1:0] {
    GLO_FSM_IDL = 3'd0,
    GLO_FSM_STR = 3'd1,
    GLO_FSM_RUN = 3'd2,
    GLO_FSM_END = 3'd3,
    GLO_FSM_ERR = 3'd4
  } glo_fsm_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LOCAL   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage

// File: rtl/mcu_global_sequencer_if.sv
// -----------------------------------------------------------------------------
// mcu_global_sequencer_if
// Purpose : Bus between the global sequencer and the NUM_LOC local fetchers.
// Signals : glo_fsm_state         global state broadcast (sequencer -> locals)
//           addr/inter/intra_counter_max  latched per-channel limits
//           loc_tlast_transmitted per-channel completion flags (locals -> seq)
//           loc_error             per-channel error flags (locals -> seq)
// Modports: master = sequencer side, slave = local-fetcher side
// -----------------------------------------------------------------------------
interface mcu_global_sequencer_if #(
  parameter int NUM_LOC          = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int INTER_ITER_WIDTH = 32,
  parameter int INTRA_ITER_WIDTH = 32
);
  import mcu_global_sequencer_pkg::*;

  logic [GLO_FSM_WIDTH-1:0]              glo_fsm_state;
  logic [NUM_LOC*(ADDR_WIDTH+1)-1:0]     addr_counter_max;
  logic [NUM_LOC*INTER_ITER_WIDTH-1:0]   inter_counter_max;
  logic [NUM_LOC*INTRA_ITER_WIDTH-1:0]   intra_counter_max;
  logic [NUM_LOC-1:0]                    loc_tlast_transmitted;
  logic [NUM_LOC-1:0]                    loc_error;

  modport master (
    output glo_fsm_state, addr_counter_max, inter_counter_max, intra_counter_max,
    input  loc_tlast_transmitted, loc_error
  );

  modport slave (
    input  glo_fsm_state, addr_counter_max, inter_counter_max, intra_counter_max,
    output loc_tlast_transmitted, loc_error
  );

endinterface

// File: rtl/mcu_global_sequencer_watchdog.sv
// -----------------------------------------------------------------------------
// mcu_watchdog
// Purpose : Progress watchdog. Saturating counter with synchronous clear and
//           count enable; flags expiry when it has reached LIMIT-1 and is
//           about to count again without being cleared. LIMIT=0 disables it.
// Ports   : clk, rst      clock, synchronous active-high reset
//           clr           clear counter (wins over en)
//           en            count this cycle
//           expired       combinational expiry flag for this cycle
// -----------------------------------------------------------------------------
module mcu_watchdog #(
  parameter int WIDTH = 24,
  parameter int LIMIT = 2**20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (LIMIT != 0) && en && !clr && (count_q == LAST);

endmodule

// File: rtl/mcu_global_sequencer.sv
// -----------------------------------------------------------------------------
// mcu_global_sequencer
// Purpose : Sequences NUM_LOC local fetch FSMs through IDL/STR/RUN/END/ERR,
//           latches per-channel limits on start, tracks completion, runs a
//           progress watchdog and reports errors. All outputs registered.
// Ports   : clk, rst             clock, synchronous active-high reset
//           start, abort         run control (start only in IDL, abort not in IDL)
//           cfg_*_max            per-channel limits, latched on accepted start
//           loc_bus (master)     glo_fsm_state / *_counter_max out,
//                                loc_tlast_transmitted / loc_error in
//           busy, done           not-IDL flag, one-cycle END pulse
//           error, err_code      sticky error and its cause
//           err_src              OR of loc_error seen while failing
// -----------------------------------------------------------------------------
module mcu_global_sequencer
  import mcu_global_sequencer_pkg::*;
#(
  parameter int NUM_LOC          = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int INTER_ITER_WIDTH = 32,
  parameter int INTRA_ITER_WIDTH = 32,
  parameter int TIMEOUT_WIDTH    = 24,
  parameter int TIMEOUT_CYCLES   = 2**20
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [NUM_LOC*(ADDR_WIDTH+1)-1:0]   cfg_addr_max,
  input  logic [NUM_LOC*INTER_ITER_WIDTH-1:0] cfg_inter_max,
  input  logic [NUM_LOC*INTRA_ITER_WIDTH-1:0] cfg_intra_max,
  mcu_global_sequencer_if.master              loc_bus,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [1:0]                          err_code,
  output logic [NUM_LOC-1:0]                  err_src
);

  localparam int AW = NUM_LOC*(ADDR_WIDTH+1);
  localparam int EW = NUM_LOC*INTER_ITER_WIDTH;
  localparam int IW = NUM_LOC*INTRA_ITER_WIDTH;

  glo_fsm_e           state_q, state_d;
  logic [AW-1:0]      addr_max_q, addr_max_d;
  logic [EW-1:0]      inter_max_q, inter_max_d;
  logic [IW-1:0]      intra_max_q, intra_max_d;
  logic [NUM_LOC-1:0] done_mask_q, done_mask_d;
  logic [NUM_LOC-1:0] err_src_q, err_src_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic               err_hold_q, err_hold_d;

  logic       start_ok, all_done, new_bit, wdg_clr, wdg_en, wdg_expired;
  logic [1:0] fail_code;

  // A start coinciding with abort is dropped rather than started-then-aborted.
  assign start_ok = start & ~abort;
  // Completion counts flags arriving this cycle, so END follows the last flag directly.
  assign all_done = &(done_mask_q | loc_bus.loc_tlast_transmitted);
  assign new_bit  = |(loc_bus.loc_tlast_transmitted & ~done_mask_q);
  assign wdg_clr  = (state_q == GLO_FSM_STR) | ((state_q == GLO_FSM_RUN) & new_bit);
  assign wdg_en   = (state_q == GLO_FSM_RUN);

  mcu_watchdog #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdg_clr),
    .en      (wdg_en),
    .expired (wdg_expired)
  );

  // Failure cause for this cycle: abort > local error > timeout.
  always_comb begin
    fail_code = ERR_NONE;
    if (abort) begin
      fail_code = ERR_ABORT;
    end else if (|loc_bus.loc_error) begin
      fail_code = ERR_LOCAL;
    end else if (wdg_expired) begin
      fail_code = ERR_TIMEOUT;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GLO_FSM_IDL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; failures take precedence over completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GLO_FSM_IDL: if (start_ok) state_d = GLO_FSM_STR;
      GLO_FSM_STR: state_d = (fail_code != ERR_NONE) ? GLO_FSM_ERR : GLO_FSM_RUN;
      GLO_FSM_RUN: begin
        if (fail_code != ERR_NONE) begin
          state_d = GLO_FSM_ERR;
        end else if (all_done) begin
          state_d = GLO_FSM_END;
        end
      end
      GLO_FSM_END: state_d = (fail_code != ERR_NONE) ? GLO_FSM_ERR : GLO_FSM_IDL;
      // err_hold_q is set after the first ERR cycle, giving a two-cycle minimum.
      GLO_FSM_ERR: if (err_hold_q && (loc_bus.loc_error == '0)) state_d = GLO_FSM_IDL;
      default:     state_d = GLO_FSM_IDL;
    endcase
  end

  // Output / datapath next values (all registered below).
  always_comb begin
    addr_max_d  = addr_max_q;
    inter_max_d = inter_max_q;
    intra_max_d = intra_max_q;
    done_mask_d = done_mask_q;
    err_src_d   = err_src_q;
    err_code_d  = err_code_q;
    error_d     = error_q;
    err_hold_d  = err_hold_q;
    busy_d      = (state_d != GLO_FSM_IDL);
    done_d      = (state_d == GLO_FSM_END);

    if ((state_q == GLO_FSM_IDL) && start_ok) begin
      addr_max_d  = cfg_addr_max;
      inter_max_d = cfg_inter_max;
      intra_max_d = cfg_intra_max;
      done_mask_d = '0;
      err_src_d   = '0;
      err_code_d  = ERR_NONE;
      error_d     = 1'b0;
    end

    if (state_q == GLO_FSM_RUN) begin
      done_mask_d = done_mask_q | loc_bus.loc_tlast_transmitted;
    end

    if (state_q == GLO_FSM_ERR) begin
      err_hold_d = 1'b1;
    end else if (state_d == GLO_FSM_ERR) begin
      error_d    = 1'b1;
      err_code_d = fail_code;
      err_hold_d = 1'b0;
    end

    // Includes the entry cycle so the flag that caused the failure is captured.
    if (state_d == GLO_FSM_ERR) begin
      err_src_d = err_src_q | loc_bus.loc_error;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_max_q  <= '0;
      inter_max_q <= '0;
      intra_max_q <= '0;
      done_mask_q <= '0;
      err_src_q   <= '0;
      err_code_q  <= ERR_NONE;
      error_q     <= 1'b0;
      err_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_max_q  <= addr_max_d;
      inter_max_q <= inter_max_d;
      intra_max_q <= intra_max_d;
      done_mask_q <= done_mask_d;
      err_src_q   <= err_src_d;
      err_code_q  <= err_code_d;
      error_q     <= error_d;
      err_hold_q  <= err_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign loc_bus.glo_fsm_state     = state_q;
  assign loc_bus.addr_counter_max  = addr_max_q;
  assign loc_bus.inter_counter_max = inter_max_q;
  assign loc_bus.intra_counter_max = intra_max_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign err_src  = err_src_q;

endmodule

// File: tb/tb_mcu_global_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mcu_global_sequencer
// Purpose : Self-checking bench for mcu_global_sequencer. Each run pushes its
//           expected END/ERR outcome (state, code, src, entry cycle) to a
//           scoreboard; a negedge monitor pops and compares on every entry
//           into END or ERR. Directed checks cover reset, limits and timing.
// -----------------------------------------------------------------------------
module tb_mcu_global_sequencer;
  import mcu_global_sequencer_pkg::*;

  localparam int NL = 4;
  localparam int AW = 32;
  localparam int EW = 32;
  localparam int IW = 32;
  localparam int TW = 24;
  localparam int TC = 16;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [NL*(AW+1)-1:0] cfg_addr_max;
  logic [NL*EW-1:0]     cfg_inter_max;
  logic [NL*IW-1:0]     cfg_intra_max;
  logic                 busy, done, error;
  logic [1:0]           err_code;
  logic [NL-1:0]        err_src;
  logic [NL-1:0]        tlast, lerr;

  mcu_global_sequencer_if #(
    .NUM_LOC(NL), .ADDR_WIDTH(AW), .INTER_ITER_WIDTH(EW), .INTRA_ITER_WIDTH(IW)
  ) bus ();

  assign bus.loc_tlast_transmitted = tlast;
  assign bus.loc_error             = lerr;

  mcu_global_sequencer #(
    .NUM_LOC(NL), .ADDR_WIDTH(AW), .INTER_ITER_WIDTH(EW), .INTRA_ITER_WIDTH(IW),
    .TIMEOUT_WIDTH(TW), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_addr_max  (cfg_addr_max),
    .cfg_inter_max (cfg_inter_max),
    .cfg_intra_max (cfg_intra_max),
    .loc_bus       (bus),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .err_src       (err_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    st;
    logic [1:0]    code;
    logic [NL-1:0] src;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   base;
  logic mon_en = 1'b0;
  logic [2:0] prev_st = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [AW:0] a, input logic [EW-1:0] e, input logic [IW-1:0] i);
    for (int c = 0; c < NL; c++) begin
      cfg_addr_max[c*(AW+1) +: AW+1] = a;
      cfg_inter_max[c*EW +: EW]      = e;
      cfg_intra_max[c*IW +: IW]      = i;
    end
  endtask

  task automatic check_limits(input string tag, input logic [AW:0] a,
                              input logic [EW-1:0] e, input logic [IW-1:0] i);
    for (int c = 0; c < NL; c++) begin
      check({tag, "_addr"},  64'(bus.addr_counter_max[c*(AW+1) +: AW+1]), 64'(a));
      check({tag, "_inter"}, 64'(bus.inter_counter_max[c*EW +: EW]),     64'(e));
      check({tag, "_intra"}, 64'(bus.intra_counter_max[c*IW +: IW]),     64'(i));
    end
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [1:0] code,
                          input logic [NL-1:0] src, input int at);
    exp_t e;
    e.st = st; e.code = code; e.src = src; e.cyc = at;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: one line per END/ERR transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy !== (bus.glo_fsm_state != GLO_FSM_IDL))
        check("busy_vs_state", 64'(busy), 64'(bus.glo_fsm_state != GLO_FSM_IDL));
      if (done !== (bus.glo_fsm_state == GLO_FSM_END))
        check("done_vs_state", 64'(done), 64'(bus.glo_fsm_state == GLO_FSM_END));
      if ((bus.glo_fsm_state != prev_st) &&
          ((bus.glo_fsm_state == GLO_FSM_END) || (bus.glo_fsm_state == GLO_FSM_ERR))) begin
        check("sb_expected_txn", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          $display("txn cyc=%0d state=%0d code=%0d src=%b done=%b error=%b",
                   cyc, bus.glo_fsm_state, err_code, err_src, done, error);
          check("sb_state", 64'(bus.glo_fsm_state), 64'(e.st));
          check("sb_cycle", 64'(cyc), 64'(e.cyc));
          check("sb_err_code", 64'(err_code), 64'(e.code));
          check("sb_err_src", 64'(err_src), 64'(e.src));
          check("sb_error", 64'(error), 64'(e.st == GLO_FSM_ERR));
        end
      end
    end
    prev_st <= bus.glo_fsm_state;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tlast = '0; lerr = '0;
    set_cfg('0, '0, '0);
    repeat (3) step();

    // Reset state
    check("rst_state", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_err_src", 64'(err_src), 64'd0);
    check_limits("rst_lim", '0, '0, '0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // 1: completions at 10,12,15,20 -> END at 21; start during END ignored.
    set_cfg(33'd4, 32'd2, 32'd1);
    base = cyc;
    push_exp(GLO_FSM_END, ERR_NONE, '0, base + 21);
    for (int c = 0; c <= 22; c++) begin
      if (c == 1) begin
        check("s1_str", 64'(bus.glo_fsm_state), 64'(GLO_FSM_STR));
        check_limits("s1_lim", 33'd4, 32'd2, 32'd1);
      end
      if (c == 2)  check("s1_run", 64'(bus.glo_fsm_state), 64'(GLO_FSM_RUN));
      if (c == 21) check("s1_done", 64'(done), 64'd1);
      if (c == 22) check("s1_idle_after_end", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
      start = (c == 0) || (c == 21);
      tlast = {c == 20, c == 15, c == 12, c == 10};
      step();
    end
    check("s1_error", 64'(error), 64'd0);

    // 2: two channels together on the final completion, with loc_error[2].
    base = cyc;
    push_exp(GLO_FSM_ERR, ERR_LOCAL, 4'b0100, base + 12);
    for (int c = 0; c <= 14; c++) begin
      if (c == 13) check("s2_err_hold", 64'(bus.glo_fsm_state), 64'(GLO_FSM_ERR));
      if (c == 14) check("s2_idle", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
      start = (c == 0);
      tlast = (c == 5) ? 4'b0001 : (c == 8) ? 4'b0010 : (c == 11) ? 4'b1100 : 4'b0000;
      lerr  = (c == 11) ? 4'b0100 : 4'b0000;
      step();
    end

    // 3a: no completion -> timeout at RUN cycle 16.
    base = cyc;
    push_exp(GLO_FSM_ERR, ERR_TIMEOUT, '0, base + 18);
    for (int c = 0; c <= 20; c++) begin
      if (c == 17) check("s3a_still_run", 64'(bus.glo_fsm_state), 64'(GLO_FSM_RUN));
      if (c == 20) check("s3a_idle", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
      start = (c == 0);
      step();
    end

    // 3b: completion at RUN cycle 8 restarts the count -> timeout at RUN cycle 24.
    base = cyc;
    push_exp(GLO_FSM_ERR, ERR_TIMEOUT, '0, base + 26);
    for (int c = 0; c <= 28; c++) begin
      if (c == 25) check("s3b_still_run", 64'(bus.glo_fsm_state), 64'(GLO_FSM_RUN));
      start = (c == 0);
      tlast = (c == 9) ? 4'b0001 : 4'b0000;
      step();
    end

    // 4: abort in RUN -> ERR code 3 for 2 cycles; abort while in ERR ignored.
    base = cyc;
    push_exp(GLO_FSM_ERR, ERR_ABORT, '0, base + 7);
    for (int c = 0; c <= 9; c++) begin
      if (c == 8) check("s4_err_hold", 64'(bus.glo_fsm_state), 64'(GLO_FSM_ERR));
      if (c == 9) check("s4_idle", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
      start = (c == 0);
      abort = (c >= 6) && (c <= 8);
      step();
    end
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("s4_start_abort_idle", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
    check("s4_start_abort_busy", 64'(busy), 64'd0);
    step();

    // 5: loc_error[1] high 5 cycles holds ERR until it drops.
    base = cyc;
    push_exp(GLO_FSM_ERR, ERR_LOCAL, 4'b0010, base + 7);
    for (int c = 0; c <= 12; c++) begin
      if (c == 11) check("s5_err_hold", 64'(bus.glo_fsm_state), 64'(GLO_FSM_ERR));
      if (c == 12) begin
        check("s5_idle", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
        check("s5_error_sticky", 64'(error), 64'd1);
      end
      start = (c == 0);
      lerr  = ((c >= 6) && (c <= 10)) ? 4'b0010 : 4'b0000;
      step();
    end
    // New start clears error and relatches; mid-run cfg change has no effect.
    set_cfg(33'd7, 32'd5, 32'd3);
    base = cyc;
    push_exp(GLO_FSM_END, ERR_NONE, '0, base + 6);
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) begin
        check("s5_error_cleared", 64'(error), 64'd0);
        check("s5_code_cleared", 64'(err_code), 64'd0);
        check_limits("s5_relatch", 33'd7, 32'd5, 32'd3);
      end
      if (c == 4) check_limits("s5_stable", 33'd7, 32'd5, 32'd3);
      if (c == 3) set_cfg(33'h1_2345_6789, 32'd9, 32'd9);
      start = (c == 0);
      tlast = (c == 5) ? 4'b1111 : 4'b0000;
      step();
    end

    // 6: start in RUN ignored; reset mid-RUN with done_mask=0011.
    base = cyc;
    for (int c = 0; c <= 9; c++) begin
      if (c == 7) check("s6_start_in_run", 64'(bus.glo_fsm_state), 64'(GLO_FSM_RUN));
      if (c == 9) begin
        check("s6_rst_state", 64'(bus.glo_fsm_state), 64'(GLO_FSM_IDL));
        check("s6_rst_busy", 64'(busy), 64'd0);
        check("s6_rst_done", 64'(done), 64'd0);
        check("s6_rst_error", 64'(error), 64'd0);
        check("s6_rst_code", 64'(err_code), 64'd0);
        check("s6_rst_src", 64'(err_src), 64'd0);
        check_limits("s6_rst_lim", '0, '0, '0);
      end
      start = (c == 0) || (c == 6);
      tlast = (c == 4) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000;
      rst   = (c == 8);
      step();
    end
    rst = 1'b0;
    repeat (2) step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
